// File: rtl/jt49_pkg.sv
// jt49_pkg: envelope register addresses, controller FSM states and the
// zero-period rule shared by the envelope blocks.
package jt49_pkg;

    localparam logic [3:0] JT49_R_ENV_FINE   = 4'hD;
    localparam logic [3:0] JT49_R_ENV_COARSE = 4'hE;
    localparam logic [3:0] JT49_R_ENV_SHAPE  = 4'hF;

    typedef enum logic [1:0] {ST_STOP, ST_RESTART, ST_RUN} env_st_e;

    // A programmed period of 0 behaves exactly like a period of 1
    function automatic logic [15:0] eff_period(input logic [15:0] p);
        return (p == 16'd0) ? 16'd1 : p;
    endfunction

endpackage

// File: rtl/jt49_env_ctrl_if.sv
// jt49_env_ctrl_if: CPU register bus plus core clock enable feeding the
// envelope controller.
interface jt49_env_ctrl_if;
    logic       cen;
    logic       wr;
    logic       rd;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cen, wr, rd, addr, din, input dout);
    modport slave  (input cen, wr, rd, addr, din, output dout);
endinterface

// File: rtl/jt49_env_div.sv
// jt49_env_div: cen prescaler and 16-bit period counter producing the
// envelope step request; clr holds both counters at zero.
module jt49_env_div #(
    parameter int PRESCALE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen_i,
    input  logic        clr_i,
    input  logic [15:0] eff_i,
    output logic        step_o
);
    localparam int            PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          tick, done;

    // >= rather than == so a lowered period ends the step at the next tick
    always_comb begin
        tick   = cen_i && (pre_q == PRE_LAST);
        done   = cnt_q >= (eff_i - 16'd1);
        step_o = !clr_i && tick && done;
        pre_d  = clr_i ? '0 : (tick ? '0 : (cen_i ? pre_q + 1'b1 : pre_q));
        cnt_d  = clr_i ? '0 : (tick ? (done ? '0 : cnt_q + 16'd1) : cnt_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jt49_env_ctrl.sv
// jt49_env_ctrl: envelope registers R13-R15, restart FSM and step strobe for jt49_eg.
// Define JT49_ENV_READ_EN to make R13-R15 readable on bus.dout.
module jt49_env_ctrl
    import jt49_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jt49_env_ctrl_if.slave        bus,
    output logic [3:0]            eg_ctrl_o,
    output logic                  eg_cen_o,
    output logic                  eg_rst_n_o
);
    env_st_e     st_q, st_d;
    logic [15:0] period_q, period_d;
    logic [3:0]  shape_q, shape_d;
    logic        hold_q, eg_cen_q, eg_rst_n_q;
    logic        wr13, wr14, wr15, clr, step;

    always_comb begin
        wr13     = bus.wr && (bus.addr == JT49_R_ENV_FINE);
        wr14     = bus.wr && (bus.addr == JT49_R_ENV_COARSE);
        wr15     = bus.wr && (bus.addr == JT49_R_ENV_SHAPE);
        period_d = {wr14 ? bus.din : period_q[15:8], wr13 ? bus.din : period_q[7:0]};
        shape_d  = wr15 ? bus.din[3:0] : shape_q;
        st_d     = wr15 ? ST_RESTART : ((st_q == ST_RESTART) ? ST_RUN : st_q);
        // hold_q keeps the counters cleared one extra clk so the first step lands at PRESCALE*eff+1
        clr      = wr15 || hold_q || (st_q != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q       <= ST_STOP;
            period_q   <= '0;
            shape_q    <= '0;
            hold_q     <= 1'b0;
            eg_cen_q   <= 1'b0;
            eg_rst_n_q <= 1'b1;
        end else begin
            st_q       <= st_d;
            period_q   <= period_d;
            shape_q    <= shape_d;
            hold_q     <= st_q == ST_RESTART;
            eg_cen_q   <= step;
            eg_rst_n_q <= !wr15;
        end
    end

    jt49_env_div #(.PRESCALE(PRESCALE)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen_i  (bus.cen),
        .clr_i  (clr),
        .eff_i  (eff_period(period_q)),
        .step_o (step)
    );

    assign eg_ctrl_o  = shape_q;
    assign eg_cen_o   = eg_cen_q;
    assign eg_rst_n_o = eg_rst_n_q;

`ifdef JT49_ENV_READ_EN
    logic [7:0] dout_q, dout_d;

    always_comb begin
        dout_d = !bus.rd ? dout_q :
                 (bus.addr == JT49_R_ENV_FINE)   ? period_q[7:0]  :
                 (bus.addr == JT49_R_ENV_COARSE) ? period_q[15:8] :
                 (bus.addr == JT49_R_ENV_SHAPE)  ? {4'b0, shape_q} : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
    end

    assign bus.dout = dout_q;
`else
    logic unused_rd;
    assign unused_rd = bus.rd;
    assign bus.dout  = 8'h00;
`endif

endmodule

// File: doc/jt49_env_ctrl.md
# jt49_env_ctrl

Envelope controller that drives the envelope generator `jt49_eg` from the CPU register interface. It decodes writes to envelope registers R13 (period fine), R14 (period coarse) and R15 (shape). It runs the prescaler and 16-bit period counter that produce the envelope step strobe. It issues the restart pulse that re-arms the generator on every shape write. It sits between the register file and `jt49_eg`, one instance per PSG.

## Interface
Parameters:
- `PRESCALE`, default 16: number of `cen` pulses per period-counter tick; legal values 8 or 16.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `cen`  in  1: core clock enable, the divided chip clock.
- `wr`  in  1: register write strobe, sampled on `clk` regardless of `cen`.
- `rd`  in  1: register read strobe.
- `addr`  in  4: register address.
- `din`  in  8: write data.
- `dout`  out  8: read data for R13–R15.
- `eg_ctrl`  out  4: shape bits {CONT, ATT, ALT, HOLD} to `jt49_eg`.
- `eg_cen`  out  1: one-`clk` envelope step strobe.
- `eg_rst_n`  out  1: one-`clk` active-low restart to `jt49_eg`.

## Operation
- **Registers**
  - `period[15:0]` = {R14, R13}.
  - `shape[3:0]` = R15[3:0]; R15[7:4] is ignored.
  - Writes to other addresses are ignored.
- **Effective period**: `eff = (period==0) ? 1 : period`.
- **Prescaler**
  - `pre` counts modulo `PRESCALE` on `cen`.
  - `tick` = `cen && pre==PRESCALE-1`.
- **Period counter**
  - `cnt[15:0]` increments on `tick`.
  - When `cnt >= eff-1`, `cnt` clears to 0 and a step is issued.
  - Because the comparison is `>=`, lowering the period mid-count ends the current step at the next tick. There is no wrap-around to 65535.
- **FSM states**
  - STOP: reset state. No `eg_cen`; `pre` and `cnt` are held at 0.
  - RESTART: lasts exactly one `clk`. `eg_rst_n`=0, `pre`=0, `cnt`=0.
  - RUN: normal stepping.
- **Transitions**
  - Any state → RESTART on a write to R15.
  - RESTART → RUN on the next `clk`.
  - Writes to R13/R14 never change state.
- **`eg_ctrl`** updates in the same edge as the R15 write. It is therefore stable during the RESTART cycle.
- **Simultaneous events**
  - R15 write on a `tick` cycle: restart wins, no step is issued, and counters clear.
  - R13/R14 write on a `tick` cycle: that cycle's comparison uses the old period; the new value applies from the next tick.
- **Reset mid-operation**
  - Returns to STOP immediately.
  - Clears `period`, `shape` and `eg_ctrl`; in-flight strobes are dropped.

## Timing
- **Reset values**: `dout`=0, `eg_ctrl`=0, `eg_cen`=0, `eg_rst_n`=1.
- **Outputs**: all are registered.
- **`eg_cen`**: high for one `clk`, on the cycle after the `tick` that satisfied the compare.
- **Step interval**: with `cen` always high, steps are exactly `PRESCALE*eff` clk apart.
- **Restart pulse**: `eg_rst_n` is low the cycle after the R15 write edge.
- **First step after restart**: `eg_cen` comes `PRESCALE*eff + 1` clk after `eg_rst_n` returns high.
- **`dout` latency**: one cycle after `rd` (see Configuration).

## Configuration
- `JT49_ENV_READ_EN` defined:
  - `rd` returns R13, R14 or R15 on `dout` one clk later; R15 reads as {4'b0, shape}.
  - Other addresses read 0.
  - `dout` holds its value until the next `rd`.
- Not defined: `dout` is constant 0 and `rd` is ignored; no read mux is synthesised.

## Structure
- **Shared package `jt49_pkg`** holds:
  - address constants `JT49_R_ENV_FINE`=4'hD, `JT49_R_ENV_COARSE`=4'hE, `JT49_R_ENV_SHAPE`=4'hF;
  - the FSM state enum `{ST_STOP, ST_RESTART, ST_RUN}`.
- **Sub-module `jt49_env_div`**: prescaler plus period counter.
  - Inputs: `cen`, `clr`, `eff`.
  - Outputs: `step`.
  - It is the natural sub-module; the top holds the registers, FSM and read mux.

## Test plan
- Reset with no writes, run 2000 clk → `eg_cen` never asserted, `eg_rst_n`=1, `eg_ctrl`=0.
- R13=1, R14=0, R15=0x0E, `cen`=1 every clk:
  - `eg_ctrl`=4'hE and `eg_rst_n` low for one clk;
  - `eg_cen` pulses exactly every 16 clk.
- R13=0, R14=0 (period 0) → identical to period 1. Then set period 3 → pulses every 48 clk.
- Period 0x0100 mid-count, then R13=0x02, R14=0 → a step on the next tick, then 32-clk spacing.
- R15 write on the exact `tick` cycle → no `eg_cen` that cycle; next `eg_cen` comes `16*eff+1` clk after `eg_rst_n` rises.
- With `JT49_ENV_READ_EN`: write R14=0xA5, R15=0xF3, then `rd` → `dout`=0xA5 and 0x03 one clk later. Assert `rst_n` low mid-run → all outputs at reset values next edge.
